// File: rtl/ddr2_arb_pkg.sv
// Shared types and constants for the DDR2 frame arbiter.
// Instruction codes, FSM encoding, counter widths, address helper.
package ddr2_arb_pkg;

  localparam int BURST_LEN    = 32;
  localparam int FRAME_BURSTS = 38;
  localparam int WR_URGENT    = 64;
  localparam logic [29:0] BUF_STRIDE = 30'h0080000;

  localparam int WCNT_W = $clog2(BURST_LEN);
  localparam int BIDX_W = $clog2(FRAME_BURSTS + 1);

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    WR_FILL,
    WR_CMD,
    RD_CMD,
    RD_DRAIN
  } arb_state_t;

  function automatic logic [29:0] burst_addr(
    input logic              b,
    input logic [BIDX_W-1:0] idx
  );
    burst_addr = (b ? BUF_STRIDE : 30'd0)
               + 30'(idx) * 30'(BURST_LEN * 8);
  endfunction

endpackage

// File: rtl/ddr2_frame_arbiter_pingpong.sv
// Ping-pong frame buffer bookkeeping: full/reading flags,
// write/read buffer selection and frame drop detection.
module fb_pingpong_mgr
  import ddr2_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic frame_done,
  input  logic frame_start,
  input  logic mid_frame,
  input  logic rd_start,
  input  logic rd_last,
  output logic wbuf,
  output logic rbuf,
  output logic frame_ready,
  output logic rd_busy,
  output logic drop
);

  logic [1:0] full;
  logic [1:0] reading;
  logic       newest;
  logic       rd_take;
  logic       sel;

  assign rd_busy     = |reading;
  assign frame_ready = full[newest] & ~reading[newest];

  // A frame completing this cycle counts as the newest for rd_start.
  assign rd_take = rd_start & ~rd_busy & (frame_ready | frame_done);
  assign sel     = frame_done ? wbuf : newest;

  assign drop = (frame_done & reading[~wbuf])
              | (frame_start & mid_frame);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full    <= '0;
      reading <= '0;
      wbuf    <= 1'b0;
      rbuf    <= 1'b0;
      newest  <= 1'b0;
    end else begin
      if (frame_done) begin
        full[wbuf] <= 1'b1;
        newest     <= wbuf;
        if (!reading[~wbuf]) begin
          wbuf        <= ~wbuf;
          full[~wbuf] <= 1'b0;
        end
      end
      if (rd_take) begin
        rbuf         <= sel;
        reading[sel] <= 1'b1;
      end
      if (rd_last) begin
        full[rbuf]    <= 1'b0;
        reading[rbuf] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ddr2_frame_arbiter.sv
// MCB port 0 arbiter: sensor writes vs host reads, ping-pong buffers.
// Optional FRAME_DROP_CNT_EN builds a saturating drop counter.
module ddr2_frame_arbiter
  import ddr2_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        calib_done,
  input  logic        frame_start,
  input  logic [9:0]  wr_fifo_count,
  output logic        wr_fifo_rd_en,
  output logic        p0_wr_en,
  input  logic        p0_wr_full,
  output logic        p0_rd_en,
  input  logic        p0_rd_empty,
  input  logic [9:0]  rd_fifo_space,
  output logic        rd_fifo_wr_en,
  output logic        p0_cmd_en,
  output logic [2:0]  p0_cmd_instr,
  output logic [5:0]  p0_cmd_bl,
  output logic [29:0] p0_cmd_addr,
  input  logic        p0_cmd_full,
  input  logic        rd_start,
  output logic        frame_ready,
  output logic        rd_done,
  output logic [7:0]  drop_count
);

  localparam logic [WCNT_W-1:0] WORD_LAST =
    WCNT_W'(BURST_LEN - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST =
    BIDX_W'(FRAME_BURSTS - 1);

  arb_state_t state, state_nx;

  logic [WCNT_W-1:0] wcnt;
  logic [BIDX_W-1:0] wr_idx;
  logic [BIDX_W-1:0] rd_idx;
  logic wr_on, last_wr, start_pend;
  logic wbuf, rbuf, rd_busy, drop;
  logic wr_ok, rd_ok, urgent;
  logic wr_pop, rd_pop, cmd_go;
  logic frame_done, rd_last, restart, mid_frame, in_wr;

  assign urgent = wr_fifo_count >= 10'(WR_URGENT);
  assign wr_ok  = wr_on & calib_done
                & (wr_fifo_count >= 10'(BURST_LEN));
  assign rd_ok  = rd_busy & calib_done
                & (rd_fifo_space >= 10'(BURST_LEN));

  assign in_wr     = (state == WR_FILL) | (state == WR_CMD);
  assign restart   = (frame_start | start_pend) & ~in_wr;
  assign mid_frame = wr_on & (wr_idx != '0);

  assign frame_done = cmd_go & (state == WR_CMD)
                    & (wr_idx == BIDX_LAST);
  assign rd_last    = rd_pop & (wcnt == WORD_LAST)
                    & (rd_idx == BIDX_LAST);

  assign wr_fifo_rd_en = wr_pop;
  assign p0_wr_en      = wr_pop;
  assign p0_rd_en      = rd_pop;
  assign rd_fifo_wr_en = rd_pop;
  assign p0_cmd_bl     = 6'(BURST_LEN - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_pop   = 1'b0;
    rd_pop   = 1'b0;
    cmd_go   = 1'b0;
    unique case (state)
      IDLE: begin
        // Urgent writes win; otherwise the last-served side yields.
        if (wr_ok && (!rd_ok || urgent || !last_wr))
          state_nx = WR_FILL;
        else if (rd_ok)
          state_nx = RD_CMD;
      end
      WR_FILL: begin
        wr_pop = !p0_wr_full;
        if (wr_pop && wcnt == WORD_LAST) state_nx = WR_CMD;
      end
      WR_CMD: begin
        cmd_go = !p0_cmd_full;
        if (cmd_go) state_nx = IDLE;
      end
      RD_CMD: begin
        cmd_go = !p0_cmd_full;
        if (cmd_go) state_nx = RD_DRAIN;
      end
      RD_DRAIN: begin
        rd_pop = !p0_rd_empty;
        if (rd_pop && wcnt == WORD_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt         <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      wr_on        <= 1'b0;
      last_wr      <= 1'b0;
      start_pend   <= 1'b0;
      p0_cmd_en    <= 1'b0;
      p0_cmd_instr <= 3'b000;
      p0_cmd_addr  <= '0;
      rd_done      <= 1'b0;
    end else begin
      if (wr_pop || rd_pop) wcnt <= wcnt + 1'b1;
      start_pend <= (frame_start | start_pend) & in_wr;
      if (state == IDLE && state_nx != IDLE)
        last_wr <= (state_nx == WR_FILL);
      if (restart) begin
        wr_on  <= 1'b1;
        wr_idx <= '0;
      end else if (cmd_go && state == WR_CMD) begin
        wr_idx <= wr_idx + 1'b1;
        if (frame_done) wr_on <= 1'b0;
      end
      if (rd_pop && wcnt == WORD_LAST)
        rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
      p0_cmd_en <= cmd_go;
      if (cmd_go) begin
        p0_cmd_instr <= (state == WR_CMD) ? INSTR_WR : INSTR_RD;
        p0_cmd_addr  <= (state == WR_CMD)
                      ? burst_addr(wbuf, wr_idx)
                      : burst_addr(rbuf, rd_idx);
      end
      rd_done <= rd_last;
    end
  end

  fb_pingpong_mgr u_pp (
    .clk         (clk),
    .reset       (reset),
    .frame_done  (frame_done),
    .frame_start (restart),
    .mid_frame   (mid_frame),
    .rd_start    (rd_start),
    .rd_last     (rd_last),
    .wbuf        (wbuf),
    .rbuf        (rbuf),
    .frame_ready (frame_ready),
    .rd_busy     (rd_busy),
    .drop        (drop)
  );

`ifdef FRAME_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_count <= '0;
    else if (drop && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end
`else
  logic drop_unused;
  assign drop_unused = drop;
  assign drop_count  = 8'h00;
`endif

endmodule
